// File: rtl/rf_writeback.sv
// Writeback front end: merges ALU and buffered load results onto the register
// file write port and tracks outstanding load destinations for decode.
module rf_writeback #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [$clog2(NREGS)-1:0] alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [$clog2(NREGS)-1:0] mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     iss_valid,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    input  logic [$clog2(NREGS)-1:0] q_a,
    input  logic [$clog2(NREGS)-1:0] q_b,
    output logic                     q_a_busy,
    output logic                     q_b_busy,
    output logic                     alu_stall,
    output logic                     rf_we,
    output logic [$clog2(NREGS)-1:0] rf_wa,
    output logic [XLEN-1:0]          rf_wd,
    output logic                     err_overrun
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ld_entry_t;

    ld_entry_t        fifo_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic [NREGS-1:0] sb, sb_nxt;

    logic             full, push, pop, commit, we_nxt, stall_nxt;
    ld_entry_t        head;
    logic [AW-1:0]    commit_rd;
    logic [XLEN-1:0]  commit_data;

    // FIFO occupancy, commit selection and scoreboard update
    always_comb begin
        full        = (count == CW'(FIFO_DEPTH));
        push        = mem_valid & ~full;
        // head is committed only if it was already stored at cycle start (no bypass)
        pop         = ~alu_valid & (count != '0);
        head        = fifo_q[rd_ptr];
        commit      = alu_valid | pop;
        commit_rd   = alu_valid ? alu_rd   : head.rd;
        commit_data = alu_valid ? alu_data : head.data;
        we_nxt      = commit & (commit_rd != '0);
        count_nxt   = count + CW'(push) - CW'(pop);
        stall_nxt   = alu_valid & (count_nxt == CW'(FIFO_DEPTH));

        // newer issue wins over a same-cycle retire of the same register
        sb_nxt = sb;
        if (pop)
            sb_nxt[head.rd] = 1'b0;
        if (iss_valid)
            sb_nxt[iss_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    assign mem_ready = ~full;
    assign q_a_busy  = sb[q_a];
    assign q_b_busy  = sb[q_b];

    // Load result storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{rd: mem_rd, data: mem_data};
    end

    // Control state and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sb          <= '0;
            alu_stall   <= 1'b0;
            err_overrun <= 1'b0;
            rf_we       <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            sb        <= sb_nxt;
            alu_stall <= stall_nxt;
            if (alu_valid & alu_stall & full)
                err_overrun <= 1'b1;
            rf_we <= we_nxt;
            if (we_nxt) begin
                rf_wa <= commit_rd;
                rf_wd <= commit_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: ALU path, load path, contention, scoreboard
// collision, overrun and mid-operation reset.
module tb_rf_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, iss_valid;
    logic [4:0]  alu_rd, mem_rd, iss_rd, q_a, q_b;
    logic [31:0] alu_data, mem_data;
    logic        mem_ready, q_a_busy, q_b_busy, alu_stall, rf_we, err_overrun;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_cmp = 0;
    int n_bad = 0;

    rf_writeback #(.XLEN(32), .NREGS(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_a(q_a), .q_b(q_b), .q_a_busy(q_a_busy), .q_b_busy(q_b_busy),
        .alu_stall(alu_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] wa, input logic [31:0] wd);
        chk({tag, ".we"}, 32'(rf_we), 32'd1);
        chk({tag, ".wa"}, 32'(rf_wa), 32'(wa));
        chk({tag, ".wd"}, rf_wd, wd);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        q_a = '0; q_b = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.we", 32'(rf_we), 0);
        chk("rst.wa", 32'(rf_wa), 0);
        chk("rst.wd", rf_wd, 0);
        chk("rst.stall", 32'(alu_stall), 0);
        chk("rst.err", 32'(err_overrun), 0);
        chk("rst.ready", 32'(mem_ready), 1);
        chk("rst.busy_a", 32'(q_a_busy), 0);
        tick();
        chk("idle.we", 32'(rf_we), 0);

        // ALU write, then rd=0 write suppressed with address/data held
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        chk_wr("alu5", 5'd5, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h11111111;
        tick();
        alu_valid = 1'b0;
        chk("alu0.we", 32'(rf_we), 0);
        chk("alu0.wa_hold", 32'(rf_wa), 5);
        chk("alu0.wd_hold", rf_wd, 32'hDEADBEEF);

        // Load path with scoreboard set and clear
        iss_valid = 1'b1; iss_rd = 5'd7; q_a = 5'd7; q_b = 5'd0;
        tick();
        iss_valid = 1'b0;
        chk("ld.busy_set", 32'(q_a_busy), 1);
        chk("ld.q0", 32'(q_b_busy), 0);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
        tick();
        mem_valid = 1'b0;
        chk("ld.n1_we", 32'(rf_we), 0);
        chk("ld.n1_busy", 32'(q_a_busy), 1);
        tick();
        chk_wr("ld.n2", 5'd7, 32'h1234);
        chk("ld.n2_busy", 32'(q_a_busy), 0);
        tick();
        chk("ld.n3_we", 32'(rf_we), 0);

        // Contention: ALU six cycles, loads rd1..4 accepted in cycles 3..6
        alu_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            alu_rd = 5'(20 + i); alu_data = 32'hA00 + 32'(i);
            if (i >= 3) begin
                mem_valid = 1'b1; mem_rd = 5'(i - 2); mem_data = 32'h100 + 32'(i - 2);
                chk("cont.ready", 32'(mem_ready), 1);
            end
            tick();
            chk_wr("cont.alu", 5'(20 + i), 32'hA00 + 32'(i));
        end
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h105;
        chk("cont.full_ready", 32'(mem_ready), 0);
        chk("cont.stall", 32'(alu_stall), 1);
        tick();
        chk_wr("cont.d1", 5'd1, 32'h101);
        chk("cont.unstall", 32'(alu_stall), 0);
        chk("cont.ready_back", 32'(mem_ready), 1);
        tick();
        mem_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            chk_wr("cont.drain", 5'(k), 32'h100 + 32'(k));
            tick();
        end
        chk("cont.empty_we", 32'(rf_we), 0);
        chk("cont.err", 32'(err_overrun), 0);

        // Same-cycle retire and reissue of r9 leaves it busy
        iss_valid = 1'b1; iss_rd = 5'd9; q_a = 5'd9; q_b = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("col.busy0", 32'(q_a_busy), 1);
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        tick();
        mem_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk_wr("col.wr", 5'd9, 32'h99);
        chk("col.busy_a", 32'(q_a_busy), 1);
        chk("col.busy_b", 32'(q_b_busy), 1);
        mem_valid = 1'b1; mem_data = 32'h9A;
        tick();
        mem_valid = 1'b0;
        tick();
        chk_wr("col.wr2", 5'd9, 32'h9A);
        chk("col.cleared", 32'(q_a_busy), 0);

        // Fill FIFO under ALU traffic, then overrun
        q_a = 5'd13; q_b = 5'd12;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB11;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(12 + i); mem_data = 32'hC00 + 32'(12 + i);
            iss_valid = (i == 0); iss_rd = 5'd13;
            tick();
        end
        mem_valid = 1'b0; iss_valid = 1'b0;
        chk("ovr.stall", 32'(alu_stall), 1);
        chk("ovr.ready", 32'(mem_ready), 0);
        chk("ovr.busy13", 32'(q_a_busy), 1);
        chk("ovr.err0", 32'(err_overrun), 0);
        alu_rd = 5'd3; alu_data = 32'h333;
        tick();
        alu_valid = 1'b0;
        chk_wr("ovr.alu3", 5'd3, 32'h333);
        chk("ovr.err1", 32'(err_overrun), 1);
        chk("ovr.stall_hold", 32'(alu_stall), 1);
        tick();
        chk_wr("ovr.d12", 5'd12, 32'hC0C);
        chk("ovr.err_sticky", 32'(err_overrun), 1);
        chk("ovr.stall_drop", 32'(alu_stall), 0);

        // Reset with three entries queued
        reset = 1'b1;
        tick();
        chk("rmid.we", 32'(rf_we), 0);
        chk("rmid.ready", 32'(mem_ready), 1);
        chk("rmid.busy_a", 32'(q_a_busy), 0);
        chk("rmid.busy_b", 32'(q_b_busy), 0);
        chk("rmid.err", 32'(err_overrun), 0);
        chk("rmid.stall", 32'(alu_stall), 0);
        reset = 1'b0;
        tick();
        chk("rmid.flushed", 32'(rf_we), 0);
        tick();
        chk("rmid.flushed2", 32'(rf_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
Writeback/commit front end that drives the register file write port and tracks pending destination registers.
- Merges two result sources:
  - ALU: single-cycle, no backpressure, highest priority.
  - Load unit: multi-cycle, valid/ready, buffered in a small FIFO.
- Keeps a pending-load scoreboard so the decode stage can stall on RAW hazards before reading operands.
- Sits between execute/memory stages and the register file.

Parameters:
XLEN, 32, data width of results and register file write data
NREGS, 32, number of architectural registers (index width = log2(NREGS))
FIFO_DEPTH, 4, load-result buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted when mem_valid&mem_ready
mem_rd  in  5  load destination register
mem_data  in  XLEN  load result
iss_valid  in  1  a load is issued this cycle
iss_rd  in  5  destination of the issued load
q_a  in  5  decode query register A
q_b  in  5  decode query register B
q_a_busy  out  1  q_a has an uncommitted load result
q_b_busy  out  1  q_b has an uncommitted load result
alu_stall  out  1  request upstream to withhold ALU results next cycle
rf_we  out  1  register file write enable
rf_wa  out  5  register file write address
rf_wd  out  XLEN  register file write data
err_overrun  out  1  sticky: ALU result arrived while alu_stall asserted and FIFO full

Behaviour:
Reset:
- rf_we=0, rf_wa=0, rf_wd=0, alu_stall=0, err_overrun=0.
- FIFO empty, so mem_ready=1 in the first cycle after reset.
- Scoreboard all clear.
Load FIFO:
- mem_ready = !full (combinational from FIFO count).
- Push on mem_valid&mem_ready.
- Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
Commit select, evaluated each cycle:
- If alu_valid: commit ALU.
- Else if FIFO non-empty: commit FIFO head, then pop.
- Else: no commit.
Write port timing:
- Registered, one-cycle latency: commit decided in cycle N appears on rf_we/rf_wa/rf_wd in cycle N+1 (regfile writes at the N+1 edge).
- rd==0 commits are consumed normally but produce rf_we=0.
- rf_wa/rf_wd hold their last values when rf_we=0.
Bypass:
- A push into an empty FIFO cannot commit in the same cycle.
- Earliest commit of a load result is the cycle after acceptance.
Stall:
- alu_stall registered: asserted for cycle N+1 when, in cycle N, the FIFO ends full (count==FIFO_DEPTH after push/pop) and ALU committed.
- Upstream guarantees alu_valid=0 while alu_stall=1, so the FIFO drains one entry per stalled cycle.
- Deasserts the cycle after count drops below FIFO_DEPTH.
- If alu_valid=1 while alu_stall=1 and the FIFO is full: ALU still commits (no data loss on ALU path) and err_overrun sets (sticky until reset).
Scoreboard (NREGS bits, bit 0 hardwired 0):
- Set bit iss_rd on iss_valid.
- Clear bit rd when a FIFO-head commit occurs for rd.
- Same-cycle set and clear of the same register: set wins (newer load outstanding).
- ALU commits never touch the scoreboard.
Busy queries:
- q_x_busy = scoreboard[q_x], combinational from registered state.
- Query of register 0 returns 0.
Reset mid-operation:
- FIFO contents discarded, scoreboard cleared.
- A commit in flight is dropped (rf_we=0 next cycle).

Test Plan:
1. ALU only: alu_valid with rd=5, data=0xDEADBEEF in cycle 1 -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle 2; rd=0 -> rf_we=0.
2. Load path: iss_valid rd=7 -> q_a=7 busy=1 next cycle. mem push rd=7, data=0x1234 in cycle N, no ALU -> write in cycle N+2, busy=0 from cycle N+2.
3. Contention: alu_valid held for 6 cycles while 5 loads are offered -> mem_ready drops after 4 accepted, alu_stall rises. After ALU stops, FIFO drains in order (rd 1,2,3,4 then 5), one write per cycle, no loss.
4. Set/clear collision: FIFO head rd=9 commits in the same cycle as iss_valid rd=9 -> q_a=9 stays busy.
5. Overrun: FIFO full, alu_stall=1, alu_valid=1 rd=3 -> ALU written next cycle, err_overrun=1 and held.
6. Reset mid-drain with 3 entries queued -> next cycle rf_we=0, mem_ready=1, all busy=0, err_overrun=0.
